reg_index_encoder: RTL and testbench
====================================

Name: reg_index_encoder

Overview:
- Converts a 32-bit register-select mask, one bit per architectural register, back into a stream of 5-bit register indices.
- This is the inverse direction of the register-address decoder.
- Used by multi-register writeback and save/restore sequencing: a mask is accepted once, then one index is emitted per cycle under valid/ready flow control until the mask is exhausted.
- A shared enable freezes the block, with the same semantics as the decoder's en.

Parameters:
- SKIP_X0, 1, when 1 bit 0 of the accepted mask is forced to 0 (x0 is never emitted)
- LSB_FIRST, 1, 1 = emit lowest set index first; 0 = highest set index first

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  block enable; 0 freezes all state and blocks both handshakes
- in_valid  input  1  mask offered
- in_ready  output  1  block can accept a mask
- in_mask  input  32  register-select mask, bit i = register i
- out_valid  output  1  out_idx is valid
- out_ready  input  1  consumer takes out_idx
- out_idx  output  5  register index being emitted
- out_last  output  1  out_idx is the final index of the current mask
- out_seq  output  5  ordinal of out_idx within the burst, 0-based
- done  output  1  one-cycle pulse when a mask is fully consumed (including empty masks)

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, pending=0, seq=0, done=0.
  - Outputs during and after reset: in_ready=0 while rst_n low; in_ready=1 after release (if en=1); out_valid=0, out_idx=0, out_last=0, out_seq=0.
- States:
  - IDLE: in_ready = en.
  - EMIT: in_ready=0, out_valid = en.
- IDLE transitions, on in_valid & in_ready:
  - pending <= in_mask with bit0 cleared if SKIP_X0; seq <= 0.
  - If the masked value is 0: stay in IDLE and pulse done on the next cycle. No out_valid is ever raised.
  - Otherwise go to EMIT. Latency is exactly 1: out_valid rises the cycle after the input handshake.
- EMIT outputs:
  - out_idx = lowest set bit of pending (LSB_FIRST=1) or highest set bit (LSB_FIRST=0).
  - out_last = 1 iff pending has exactly one bit set.
  - out_seq = seq.
- EMIT transitions, on out_valid & out_ready:
  - Clear the out_idx bit in pending; seq <= seq+1.
  - If out_last: go to IDLE and assert done for exactly one cycle (the cycle after the final handshake).
- Sustained throughput is one index per cycle while out_ready=1. A 31-bit burst completes in 31 handshake cycles.
- Stall rule: while out_valid=1 and out_ready=0, out_idx, out_last and out_seq are held stable.
- All outputs are functions of registered state plus en only. There is no combinational path from in_mask, in_valid or out_ready to any output.
- en=0:
  - in_ready=0, out_valid=0, done=0; state, pending and seq are held.
  - On en returning to 1, emission resumes at the same index and seq.
  - A done pulse that falls in a cycle with en=0 is deferred to the first cycle with en=1.
- Counter width: seq is 5 bits. With SKIP_X0=0 and mask 0xFFFFFFFF, seq wraps from 31 to 0 only after the last handshake; the final out_seq is 31.
- Reset mid-burst: pending is discarded, no done is pulsed, and the block is in IDLE after release.
- in_valid while in EMIT: ignored (in_ready=0). The mask must be held by the producer.

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5, REG_COUNT=32
  - state enum {IDLE, EMIT}
  - the x0 index constant (0)
- One natural sub-module: reg_prio_encode.
  - Purely combinational: 32-bit vector -> 5-bit index + any flag + single-bit flag.
  - Direction is selected by a parameter.
  - Instantiated once on pending.

Test Plan:
- Mask with steady out_ready: in_mask=0x00000016, out_ready=1 -> idx 1,2,4 on consecutive cycles; seq 0,1,2; out_last only on idx 4; done pulses one cycle after the idx-4 handshake.
- Empty-after-masking input: in_mask=0x00000001, SKIP_X0=1 -> out_valid never rises; done pulses one cycle after acceptance; in_ready stays 1.
- Full mask, back-to-back: in_mask=0xFFFFFFFF, out_ready=1 -> idx 1..31 in 31 consecutive cycles. With SKIP_X0=0 the same mask gives idx 0..31 and final out_seq=31.
- Backpressure and enable freeze: in_mask=0x80000101, LSB_FIRST=0, out_ready low for 3 cycles, then en low for 2 cycles -> idx 31 held stable throughout; then idx 31, 8, 0→(skipped: idx 8 last); seq resumes unchanged.
- Reset mid-burst: in_mask=0x0000F000, rst_n low after 2 indices (12,13) -> outputs go to 0 immediately (async); no done pulse; next mask 0x4 yields idx 2 with seq 0.

Source files
------------

// File: rtl/reg_index_encoder_pkg.sv
// Shared definitions for the register-index encoder: address/count widths,
// the x0 index constant and the sequencing state type.
package reg_index_encoder_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_COUNT  = 32;

  localparam logic [REG_ADDR_W-1:0] X0_IDX = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/reg_prio_encode.sv
// Combinational priority encoder over a register mask: selected index,
// any-bit-set flag and exactly-one-bit-set flag. Direction set by LSB_FIRST.
module reg_prio_encode
  import reg_index_encoder_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [REG_COUNT-1:0]  vec_i,
  output logic [REG_ADDR_W-1:0] idx_o,
  output logic                  any_o,
  output logic                  single_o
);

  // Later loop iterations win, so scan from the low-priority end.
  always_comb begin
    int k;
    idx_o = X0_IDX;
    k     = 0;
    for (int i = 0; i < REG_COUNT; i++) begin
      k     = LSB_FIRST ? (REG_COUNT - 1 - i) : i;
      idx_o = vec_i[k] ? REG_ADDR_W'(k) : idx_o;
    end
  end

  assign any_o    = |vec_i;
  assign single_o = any_o && ((vec_i & (vec_i - 32'd1)) == 32'd0);

endmodule

// File: rtl/reg_index_encoder.sv
// Accepts a 32-bit register-select mask and emits one 5-bit register index
// per cycle under valid/ready flow control, with a done pulse per mask.
module reg_index_encoder
  import reg_index_encoder_pkg::*;
#(
  parameter bit SKIP_X0   = 1'b1,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_COUNT-1:0]  in_mask,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_idx,
  output logic                  out_last,
  output logic [REG_ADDR_W-1:0] out_seq,
  output logic                  done
);

  state_e                  state_q, state_d;
  logic [REG_COUNT-1:0]    pending_q, pending_d;
  logic [REG_ADDR_W-1:0]   seq_q, seq_d;
  logic                    done_q, done_d;

  logic [REG_COUNT-1:0]    mask_s;
  logic [REG_ADDR_W-1:0]   enc_idx_s;
  logic                    enc_any_s;
  logic                    enc_single_s;
  logic                    in_hs_s;
  logic                    out_hs_s;
  logic                    emit_s;

  assign mask_s = SKIP_X0 ? {in_mask[REG_COUNT-1:1], 1'b0} : in_mask;

  reg_prio_encode #(
    .LSB_FIRST (LSB_FIRST)
  ) u_prio (
    .vec_i    (pending_q),
    .idx_o    (enc_idx_s),
    .any_o    (enc_any_s),
    .single_o (enc_single_s)
  );

  assign emit_s    = (state_q == EMIT);
  assign in_ready  = rst_n & en & (state_q == IDLE);
  assign out_valid = emit_s & en;
  assign out_idx   = emit_s ? enc_idx_s : X0_IDX;
  assign out_last  = emit_s & enc_single_s;
  assign out_seq   = emit_s ? seq_q : 5'd0;
  assign done      = done_q & en;

  assign in_hs_s  = in_valid & in_ready;
  assign out_hs_s = out_valid & out_ready;

  // Next-state logic; a pending done is only retired in a cycle where en shows it.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    seq_d     = seq_q;
    done_d    = done_q & ~en;
    case (state_q)
      IDLE: begin
        if (in_hs_s) begin
          pending_d = mask_s;
          seq_d     = 5'd0;
          if (mask_s == 32'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = EMIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (out_hs_s) begin
          pending_d = pending_q & ~(32'd1 << enc_idx_s);
          seq_d     = seq_q + 5'd1;
          if (enc_single_s || !enc_any_s) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = EMIT;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 32'd0;
      seq_q     <= 5'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      seq_q     <= seq_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_reg_index_encoder.sv
// Directed bench for reg_index_encoder: three parameterisations sharing clock,
// reset, enable and mask, each with its own valid/ready.
module tb_reg_index_encoder;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [31:0] in_mask;

  logic        iv_a, ordy_a, ir_a, ov_a, last_a, done_a;
  logic [4:0]  idx_a, seq_a;
  logic        iv_b, ordy_b, ir_b, ov_b, last_b, done_b;
  logic [4:0]  idx_b, seq_b;
  logic        iv_c, ordy_c, ir_c, ov_c, last_c, done_c;
  logic [4:0]  idx_c, seq_c;

  int total;
  int bad;

  reg_index_encoder #(.SKIP_X0(1'b1), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv_a), .in_ready(ir_a),
    .in_mask(in_mask), .out_valid(ov_a), .out_ready(ordy_a), .out_idx(idx_a),
    .out_last(last_a), .out_seq(seq_a), .done(done_a)
  );

  reg_index_encoder #(.SKIP_X0(1'b0), .LSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv_b), .in_ready(ir_b),
    .in_mask(in_mask), .out_valid(ov_b), .out_ready(ordy_b), .out_idx(idx_b),
    .out_last(last_b), .out_seq(seq_b), .done(done_b)
  );

  reg_index_encoder #(.SKIP_X0(1'b1), .LSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .in_valid(iv_c), .in_ready(ir_c),
    .in_mask(in_mask), .out_valid(ov_c), .out_ready(ordy_c), .out_idx(idx_c),
    .out_last(last_c), .out_seq(seq_c), .done(done_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic ov, input logic [4:0] idx, input logic [4:0] seq, input logic last,
                         input logic e_ov, input logic [4:0] e_idx, input logic [4:0] e_seq, input logic e_last);
    chk({tag, ".valid"}, {31'd0, ov}, {31'd0, e_ov});
    chk({tag, ".idx"},   {27'd0, idx}, {27'd0, e_idx});
    chk({tag, ".seq"},   {27'd0, seq}, {27'd0, e_seq});
    chk({tag, ".last"},  {31'd0, last}, {31'd0, e_last});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    en      = 1'b1;
    in_mask = 32'd0;
    iv_a = 1'b0; ordy_a = 1'b0;
    iv_b = 1'b0; ordy_b = 1'b0;
    iv_c = 1'b0; ordy_c = 1'b0;

    // reset state
    #2;
    chk("rst.ready", {31'd0, ir_a}, 32'd0);
    chk("rst.done", {31'd0, done_a}, 32'd0);
    chk_out("rst", ov_a, idx_a, seq_a, last_a, 1'b0, 5'd0, 5'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("rel.ready", {31'd0, ir_a}, 32'd1);
    step();

    // mask 0x16, steady out_ready: 1,2,4
    in_mask = 32'h0000_0016; iv_a = 1'b1; ordy_a = 1'b1;
    step();
    iv_a = 1'b0;
    chk_out("t1.0", ov_a, idx_a, seq_a, last_a, 1'b1, 5'd1, 5'd0, 1'b0);
    chk("t1.ready_busy", {31'd0, ir_a}, 32'd0);
    chk("t1.done0", {31'd0, done_a}, 32'd0);
    step();
    chk_out("t1.1", ov_a, idx_a, seq_a, last_a, 1'b1, 5'd2, 5'd1, 1'b0);
    step();
    chk_out("t1.2", ov_a, idx_a, seq_a, last_a, 1'b1, 5'd4, 5'd2, 1'b1);
    step();
    chk("t1.valid_end", {31'd0, ov_a}, 32'd0);
    chk("t1.done", {31'd0, done_a}, 32'd1);
    chk("t1.ready_end", {31'd0, ir_a}, 32'd1);
    step();
    chk("t1.done_off", {31'd0, done_a}, 32'd0);

    // mask 0x1 with x0 skipped: empty burst
    in_mask = 32'h0000_0001; iv_a = 1'b1;
    step();
    iv_a = 1'b0;
    chk("t2.valid", {31'd0, ov_a}, 32'd0);
    chk("t2.done", {31'd0, done_a}, 32'd1);
    chk("t2.ready", {31'd0, ir_a}, 32'd1);
    step();
    chk("t2.valid2", {31'd0, ov_a}, 32'd0);
    chk("t2.done_off", {31'd0, done_a}, 32'd0);

    // full mask, x0 skipped: idx 1..31
    in_mask = 32'hFFFF_FFFF; iv_a = 1'b1;
    step();
    iv_a = 1'b0;
    for (int i = 0; i < 31; i++) begin
      chk_out("t3a", ov_a, idx_a, seq_a, last_a, 1'b1, 5'(i + 1), 5'(i), (i == 30));
      step();
    end
    chk("t3a.valid_end", {31'd0, ov_a}, 32'd0);
    chk("t3a.done", {31'd0, done_a}, 32'd1);
    ordy_a = 1'b0;

    // full mask, x0 kept: idx 0..31, final seq 31
    iv_b = 1'b1; ordy_b = 1'b1;
    step();
    iv_b = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk_out("t3b", ov_b, idx_b, seq_b, last_b, 1'b1, 5'(i), 5'(i), (i == 31));
      step();
    end
    chk("t3b.valid_end", {31'd0, ov_b}, 32'd0);
    chk("t3b.done", {31'd0, done_b}, 32'd1);
    ordy_b = 1'b0;
    step();

    // MSB-first with backpressure, enable freeze and deferred done
    in_mask = 32'h8000_0101; iv_c = 1'b1; ordy_c = 1'b0;
    step();
    iv_c = 1'b0;
    chk_out("t4.first", ov_c, idx_c, seq_c, last_c, 1'b1, 5'd31, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("t4.stall", ov_c, idx_c, seq_c, last_c, 1'b1, 5'd31, 5'd0, 1'b0);
    end
    en = 1'b0; ordy_c = 1'b1;
    #1;
    chk_out("t4.en0", ov_c, idx_c, seq_c, last_c, 1'b0, 5'd31, 5'd0, 1'b0);
    chk("t4.en0_ready", {31'd0, ir_a}, 32'd0);
    step();
    step();
    chk_out("t4.en0b", ov_c, idx_c, seq_c, last_c, 1'b0, 5'd31, 5'd0, 1'b0);
    en = 1'b1;
    #1;
    chk_out("t4.resume", ov_c, idx_c, seq_c, last_c, 1'b1, 5'd31, 5'd0, 1'b0);
    step();
    chk_out("t4.second", ov_c, idx_c, seq_c, last_c, 1'b1, 5'd8, 5'd1, 1'b1);
    step();
    en = 1'b0;
    #1;
    chk("t4.done_held", {31'd0, done_c}, 32'd0);
    chk("t4.valid_end", {31'd0, ov_c}, 32'd0);
    step();
    chk("t4.done_held2", {31'd0, done_c}, 32'd0);
    en = 1'b1;
    #1;
    chk("t4.done_defer", {31'd0, done_c}, 32'd1);
    step();
    chk("t4.done_off", {31'd0, done_c}, 32'd0);
    ordy_c = 1'b0;

    // reset mid-burst
    in_mask = 32'h0000_F000; iv_a = 1'b1; ordy_a = 1'b1;
    step();
    iv_a = 1'b0;
    chk_out("t5.0", ov_a, idx_a, seq_a, last_a, 1'b1, 5'd12, 5'd0, 1'b0);
    step();
    chk_out("t5.1", ov_a, idx_a, seq_a, last_a, 1'b1, 5'd13, 5'd1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_out("t5.rst", ov_a, idx_a, seq_a, last_a, 1'b0, 5'd0, 5'd0, 1'b0);
    chk("t5.rst_ready", {31'd0, ir_a}, 32'd0);
    chk("t5.rst_done", {31'd0, done_a}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t5.no_done", {31'd0, done_a}, 32'd0);
    chk("t5.idle_ready", {31'd0, ir_a}, 32'd1);
    chk("t5.idle_valid", {31'd0, ov_a}, 32'd0);
    in_mask = 32'h0000_0004; iv_a = 1'b1;
    step();
    iv_a = 1'b0;
    chk_out("t5.next", ov_a, idx_a, seq_a, last_a, 1'b1, 5'd2, 5'd0, 1'b1);
    step();
    chk("t5.next_done", {31'd0, done_a}, 32'd1);
    chk("t5.next_valid", {31'd0, ov_a}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
